ofdm_data_framer: RTL and testbench

//  Builds the 802.11a DATA field (SERVICE + PSDU + tail + pad) for one PPDU and streams it out bit-serially, scrambled.

---
 rtl/ofdm_data_framer.sv | 236 +++++++++++++++++++++++
 tb/tb_ofdm_data_framer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_data_framer.sv
// ofdm_data_framer
//   Builds the 802.11a DATA field for one PPDU and streams it out bit-serially.
//   The field is SERVICE (16 zero bits), the PSDU (LSB first), a 6-bit tail and
//   pad bits up to a whole OFDM symbol. Everything except the tail is scrambled
//   with x^7+x^4+1, which restarts from SEED at every frame.
//
//   Build option FRAMER_SIGNAL_EN: when defined, the 24-bit SIGNAL field is
//   sent unscrambled ahead of SERVICE.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   start_req/rate/len        frame request, sampled only while idle
//   start_ack / start_err     1-cycle accept / reject pulses
//   in_data/in_valid/in_ready PSDU byte stream
//   out_bit/out_valid/out_ready  framed serial bit stream
//   busy                      high from start_ack until the done cycle
//   done                      pulses with the transfer of the final bit
module ofdm_data_framer #(
  parameter int         LEN_MAX = 200,
  parameter logic [6:0] SEED    = 7'h5D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_req,
  input  logic [3:0]  start_rate,
  input  logic [11:0] start_len,
  output logic        start_ack,
  output logic        start_err,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [11:0] LEN_MAX_C = 12'(LEN_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SIGNAL, S_SERVICE, S_PSDU, S_TAIL, S_PAD
  } state_t;

  state_t      r_state;
  logic [6:0]  r_scr;
  logic [7:0]  r_ndbps;
  logic [7:0]  r_sym;       // bit position within the current OFDM symbol
  logic [4:0]  r_cnt;       // bit counter for SIGNAL / SERVICE / TAIL
  logic [11:0] r_byte_rem;  // PSDU bytes still to be accepted
  logic [7:0]  r_sreg;
  logic [3:0]  r_sbits;     // bits left in r_sreg
  logic        r_ack, r_err, r_busy;
`ifdef FRAMER_SIGNAL_EN
  logic [23:0] r_sig;
`endif

  // Output slot: the raw bit plus how to treat it when it transfers. The
  // scrambler is only applied and advanced on the transfer itself, so a
  // stalled bit keeps a stable value.
  logic        r_ov, r_od, r_omix, r_oadv, r_olast;

  logic        w_fb, w_xfer, w_slot_free, w_sym_wrap;
  logic        w_rate_ok, w_len_ok;
  logic [7:0]  w_ndbps;

  assign w_fb        = r_scr[6] ^ r_scr[3];
  assign w_xfer      = r_ov & out_ready;
  assign w_slot_free = ~r_ov | w_xfer;
  assign w_sym_wrap  = (r_sym == r_ndbps - 8'd1);
  assign w_len_ok    = (start_len != 12'd0) && (start_len <= LEN_MAX_C);

  always_comb begin
    w_rate_ok = 1'b1;
    w_ndbps   = 8'd24;
    case (start_rate)
      4'b1011: w_ndbps = 8'd24;
      4'b1111: w_ndbps = 8'd36;
      4'b1010: w_ndbps = 8'd48;
      4'b1110: w_ndbps = 8'd72;
      4'b1001: w_ndbps = 8'd96;
      4'b1101: w_ndbps = 8'd144;
      4'b1000: w_ndbps = 8'd192;
      4'b1100: w_ndbps = 8'd216;
      default: w_rate_ok = 1'b0;
    endcase
  end

  assign start_ack = r_ack;
  assign start_err = r_err;
  assign busy      = r_busy;
  assign out_valid = r_ov;
  assign out_bit   = r_od ^ (r_omix & w_fb);
  assign done      = w_xfer & r_olast;
  assign in_ready  = (r_state == S_PSDU) && (r_sbits == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_scr      <= SEED;
      r_ndbps    <= 8'd24;
      r_sym      <= 8'd0;
      r_cnt      <= 5'd0;
      r_byte_rem <= 12'd0;
      r_sreg     <= 8'd0;
      r_sbits    <= 4'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_ov       <= 1'b0;
      r_od       <= 1'b0;
      r_omix     <= 1'b0;
      r_oadv     <= 1'b0;
      r_olast    <= 1'b0;
`ifdef FRAMER_SIGNAL_EN
      r_sig      <= 24'd0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;

      if (w_xfer) begin
        if (r_oadv)  r_scr  <= {r_scr[5:0], w_fb};
        if (r_olast) r_busy <= 1'b0;
      end

      // Slot empties by default; a generating state below refills it.
      if (w_slot_free) begin
        r_ov    <= 1'b0;
        r_od    <= 1'b0;
        r_omix  <= 1'b0;
        r_oadv  <= 1'b0;
        r_olast <= 1'b0;
      end

      if (in_ready && in_valid) begin
        r_sreg     <= in_data;
        r_sbits    <= 4'd8;
        r_byte_rem <= r_byte_rem - 12'd1;
      end

      case (r_state)
        S_IDLE: begin
          // busy still high means the last bit has not transferred yet
          if (start_req && !r_busy) begin
            if (w_rate_ok && w_len_ok) begin
              r_ack      <= 1'b1;
              r_busy     <= 1'b1;
              r_ndbps    <= w_ndbps;
              r_byte_rem <= start_len;
              r_sym      <= 8'd0;
              r_cnt      <= 5'd0;
              r_sbits    <= 4'd0;
              r_scr      <= SEED;
`ifdef FRAMER_SIGNAL_EN
              r_sig      <= {6'b0, ^{start_rate, 1'b0, start_len}, start_len, 1'b0, start_rate};
              r_state    <= S_SIGNAL;
`else
              r_state    <= S_SERVICE;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end

`ifdef FRAMER_SIGNAL_EN
        S_SIGNAL: if (w_slot_free) begin
          r_ov  <= 1'b1;
          r_od  <= r_sig[0];
          r_sig <= r_sig >> 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            r_cnt   <= 5'd0;
            r_state <= S_SERVICE;
          end
        end
`endif

        S_SERVICE: if (w_slot_free) begin
          r_ov   <= 1'b1;
          r_omix <= 1'b1;
          r_oadv <= 1'b1;
          r_sym  <= w_sym_wrap ? 8'd0 : r_sym + 8'd1;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            r_cnt   <= 5'd0;
            r_state <= S_PSDU;
          end
        end

        S_PSDU: if (w_slot_free && r_sbits != 4'd0) begin
          r_ov    <= 1'b1;
          r_od    <= r_sreg[0];
          r_omix  <= 1'b1;
          r_oadv  <= 1'b1;
          r_sreg  <= r_sreg >> 1;
          r_sbits <= r_sbits - 4'd1;
          r_sym   <= w_sym_wrap ? 8'd0 : r_sym + 8'd1;
          if (r_sbits == 4'd1 && r_byte_rem == 12'd0) r_state <= S_TAIL;
        end

        S_TAIL: if (w_slot_free) begin
          // tail bits go out as zero but still clock the scrambler
          r_ov   <= 1'b1;
          r_oadv <= 1'b1;
          r_sym  <= w_sym_wrap ? 8'd0 : r_sym + 8'd1;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd5) begin
            r_cnt <= 5'd0;
            if (w_sym_wrap) begin
              r_olast <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_PAD;
            end
          end
        end

        S_PAD: if (w_slot_free) begin
          r_ov   <= 1'b1;
          r_omix <= 1'b1;
          r_oadv <= 1'b1;
          r_sym  <= w_sym_wrap ? 8'd0 : r_sym + 8'd1;
          if (w_sym_wrap) begin
            r_olast <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_data_framer.sv
// Directed bench for ofdm_data_framer: builds the expected DATA-field bit
// stream from the field layout and the x^7+x^4+1 scrambler, then compares it
// with what the DUT transfers.
module tb_ofdm_data_framer;

  localparam logic [6:0] SEED_TB = 7'h7F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_req = 1'b0;
  logic [3:0]  start_rate = 4'd0;
  logic [11:0] start_len = 12'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        start_ack, start_err, in_ready, out_bit, out_valid, busy, done;

  ofdm_data_framer #(.LEN_MAX(200), .SEED(SEED_TB)) dut (
    .clock(clock), .reset(reset),
    .start_req(start_req), .start_rate(start_rate), .start_len(start_len),
    .start_ack(start_ack), .start_err(start_err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

`ifdef FRAMER_SIGNAL_EN
  localparam int SO = 24;
`else
  localparam int SO = 0;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] psdu [0:255];
  bit   exp_q [$];
  bit   got_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int ndbps(input logic [3:0] r);
    case (r)
      4'b1011: return 24;   4'b1111: return 36;
      4'b1010: return 48;   4'b1110: return 72;
      4'b1001: return 96;   4'b1101: return 144;
      4'b1000: return 192;  default: return 216;
    endcase
  endfunction

  task automatic build_exp(input logic [3:0] rate, input int len);
    int nd, nb, npad;
    logic [6:0] s;
    bit d, fb;
    logic [23:0] sig;
    exp_q.delete();
    sig = {6'b0, ^{rate, 1'b0, 12'(len)}, 12'(len), 1'b0, rate};
    for (int i = 0; i < SO; i++) exp_q.push_back(sig[i]);
    nd   = ndbps(rate);
    nb   = 22 + 8 * len;
    npad = (nd - (nb % nd)) % nd;
    s    = SEED_TB;
    for (int i = 0; i < nb + npad; i++) begin
      d = 1'b0;
      if (i >= 16 && i < 16 + 8 * len) d = psdu[(i - 16) / 8][(i - 16) % 8];
      fb = s[6] ^ s[3];
      if (i >= 16 + 8 * len && i < 22 + 8 * len) exp_q.push_back(1'b0);
      else exp_q.push_back(d ^ fb);
      s = {s[5:0], fb};
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] rate, input int len,
                           input bit rnd, input int abort_at, input bit poke);
    int cyc, idx, done_at, busy_bad, extra, nerr, tl;
    bit fin;
    build_exp(rate, len);
    got_q.delete();
    @(posedge clock); #1;
    start_req = 1'b1; start_rate = rate; start_len = 12'(len);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1;
    start_req = 1'b0;
    @(negedge clock);
    chk({tag, "_ack"}, {start_ack, start_err, busy, out_valid}, 4'b1010);
    fin = 0; cyc = 0; idx = 0; done_at = 0; busy_bad = 0; extra = 0;
    while (!fin && cyc < 20000) begin
      @(posedge clock); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < len && (!rnd || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1; in_data = psdu[idx];
      end else begin
        in_valid = 1'b0; in_data = 8'h00;
      end
      start_req = poke && (cyc == 40);
      @(negedge clock);
      if (cyc == 0) chk({tag, "_latency"}, 32'(out_valid), 32'd1);
      if (busy !== 1'b1) busy_bad++;
      if (start_ack || start_err) extra++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_bit);
        if (done) done_at = got_q.size();
      end
      if (done) fin = 1;
      if (in_valid && in_ready) idx++;
      cyc++;
      if (abort_at > 0 && got_q.size() >= abort_at) break;
    end
    start_req = 1'b0; in_valid = 1'b0;
    nerr = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) nerr++;
    chk({tag, "_stream"}, 32'(nerr), 32'd0);
    if (abort_at > 0) begin
      chk({tag, "_abort_pt"}, 32'(got_q.size()), 32'(abort_at));
    end else begin
      chk({tag, "_bits"}, 32'(got_q.size()), 32'(exp_q.size()));
      chk({tag, "_done_at"}, 32'(done_at), 32'(exp_q.size()));
      chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
      chk({tag, "_busy_req"}, 32'(extra), 32'd0);
      tl = 0;
      for (int i = SO + 16 + 8 * len; i < SO + 22 + 8 * len && i < got_q.size(); i++)
        tl += int'(got_q[i]);
      chk({tag, "_tail0"}, 32'(tl), 32'd0);
      @(negedge clock);
      chk({tag, "_idle"}, {busy, done, out_valid}, 3'b000);
    end
  endtask

  task automatic bad_req(input string tag, input logic [3:0] rate, input logic [11:0] len);
    @(posedge clock); #1;
    start_req = 1'b1; start_rate = rate; start_len = len;
    @(posedge clock); #1;
    start_req = 1'b0;
    @(negedge clock);
    chk(tag, {start_err, start_ack, busy}, 3'b100);
    @(negedge clock);
    chk({tag, "_pulse"}, {start_err, start_ack, busy}, 3'b000);
  endtask

  task automatic chk_first16(input string tag);
    logic [15:0] v;
    logic [15:0] ref16;
    ref16 = 16'b0000111011110010;
    v = 16'd0;
    for (int i = 0; i < 16; i++) v = {v[14:0], got_q[SO + i]};
    chk(tag, 32'(v), 32'(ref16));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) psdu[i] = 8'($urandom);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset", {start_ack, start_err, in_ready, out_bit, out_valid, busy, done}, 7'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: len 1, zero byte, 48 bits (18 pad)
    psdu[0] = 8'h00;
    run_frame("t1", 4'b1011, 1, 0, 0, 0);
    chk_first16("t1_first16");
    chk("t1_len", 32'(got_q.size()), 32'(48 + SO));

`ifdef FRAMER_SIGNAL_EN
    begin
      logic [23:0] v, ref24;
      ref24 = 24'b110100010011000000000000;
      psdu[0] = 8'($urandom);
      run_frame("t6", 4'b1011, 100, 0, 0, 0);
      v = 24'd0;
      for (int i = 0; i < 24; i++) v = {v[22:0], got_q[i]};
      chk("t6_signal", 32'(v), 32'(ref24));
    end
`endif

    // 2: len 100 at NDBPS 144, with a start_req poked mid-frame
    psdu[0] = 8'h5A;
    run_frame("t2", 4'b1101, 100, 0, 0, 1);
    chk("t2_len", 32'(got_q.size()), 32'(864 + SO));

    // 3: same frame under random back-pressure and input gaps
    run_frame("t3", 4'b1101, 100, 1, 0, 0);

    // 4: rejected requests
    bad_req("err_rate", 4'b0000, 12'd5);
    bad_req("err_len0", 4'b1011, 12'd0);
    bad_req("err_lenmax", 4'b1011, 12'd201);

    // LEN_MAX itself is accepted: 1622 bits padded to 1728 at NDBPS 216
    run_frame("lenmax", 4'b1100, 200, 0, 0, 0);
    chk("lenmax_len", 32'(got_q.size()), 32'(1728 + SO));

    // 5: abort at bit 300, then a fresh len-1 frame from SEED
    run_frame("t5a", 4'b1101, 100, 0, 300, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t5_reset", {start_ack, start_err, in_ready, out_bit, out_valid, busy, done}, 7'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    psdu[0] = 8'h00;
    run_frame("t5b", 4'b1011, 1, 0, 0, 0);
    chk_first16("t5b_first16");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
